// File: rtl/tick_bcd_stopwatch_pkg.sv
// Shared types and constants for the tick-driven BCD stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUNNING  = 2'd1,
    STOPPED  = 2'd2,
    OVERFLOW = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit_cnt.sv
// Single decimal digit counter (0..9) with synchronous clear and ripple carry-out.
module bcd_digit_cnt
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc) begin
      q_d = (q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign carry = inc & (q_q == BCD_MAX);

endmodule

// File: rtl/tick_bcd_stopwatch.sv
// Stopwatch core: counts divider ticks in packed BCD under start/stop/clear control.
module tick_bcd_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  running,
  output logic                  overflow,
  output logic                  done
);

  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{BCD_MAX}};

  state_e state_q, state_d;
  logic   done_q, done_d;

  logic [4*DIGITS-1:0] digits;
  logic [DIGITS:0]     carry_chain;
  logic                ovf_hit;

  assign carry_chain[0] = tick & (state_q == RUNNING) & ~clear;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_cnt u_digit (
      .clk   (clk),
      .rst   (rst),
      .clr   (clear),
      .inc   (carry_chain[i]),
      .q     (digits[4*i +: 4]),
      .carry (carry_chain[i+1])
    );
  end

  // Carry out of the top digit is exactly tick & running & all-nines.
  assign ovf_hit = carry_chain[DIGITS];

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:     if (start && !stop) state_d = RUNNING;
        RUNNING: begin
          if (ovf_hit)   state_d = OVERFLOW;
          else if (stop) state_d = STOPPED;
        end
        STOPPED:  if (start) state_d = RUNNING;
        OVERFLOW: state_d = OVERFLOW;
        default:  state_d = IDLE;
      endcase
    end
    done_d = (state_d != state_q) && ((state_d == STOPPED) || (state_d == OVERFLOW));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Digits wrap to zero on the overflowing tick; the held 9s come from the state register.
  assign bcd      = (state_q == OVERFLOW) ? ALL_NINES : digits;
  assign running  = (state_q == RUNNING);
  assign overflow = (state_q == OVERFLOW);
  assign done     = done_q;

endmodule

// File: tb/tb_tick_bcd_stopwatch.sv
// Self-checking bench for tick_bcd_stopwatch against an integer-count reference model.
module tb_tick_bcd_stopwatch;

  localparam int unsigned DIGITS = 4;
  localparam int MAXCNT = 9999;
  localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2, M_OVF = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                tick = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic [4*DIGITS-1:0] bcd;
  logic                running, overflow, done;

  int errors = 0;
  int checks = 0;

  int m_count = 0;
  int m_state = M_IDLE;
  bit m_done  = 1'b0;

  tick_bcd_stopwatch #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .bcd      (bcd),
    .running  (running),
    .overflow (overflow),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'((n / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic model_step(input bit t, input bit s, input bit p, input bit c);
    int prev;
    prev = m_state;
    if (c) begin
      m_count = 0;
      m_state = M_IDLE;
    end else begin
      case (m_state)
        M_IDLE: if (s && !p) m_state = M_RUN;
        M_RUN: begin
          if (t && m_count == MAXCNT) m_state = M_OVF;
          else begin
            if (t) m_count = m_count + 1;
            if (p) m_state = M_STOP;
          end
        end
        M_STOP: if (s) m_state = M_RUN;
        default: ;
      endcase
    end
    m_done = (m_state != prev) && (m_state == M_STOP || m_state == M_OVF);
  endtask

  task automatic check_all();
    chk("bcd", 32'(bcd), 32'(to_bcd(m_count)));
    chk("running", 32'(running), 32'(m_state == M_RUN));
    chk("overflow", 32'(overflow), 32'(m_state == M_OVF));
    chk("done", 32'(done), 32'(m_done));
  endtask

  task automatic cyc(input bit t, input bit s, input bit p, input bit c);
    tick = t; start = s; stop = p; clear = c;
    @(posedge clk);
    model_step(t, s, p, c);
    #1;
    tick = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  int done_seen;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_bcd", 32'(bcd), 32'h0);
    chk("reset_running", 32'(running), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 37 spaced ticks, stop, then ticks are ignored
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 37; i++) begin
      cyc(1, 0, 0, 0);
      repeat (4) cyc(0, 0, 0, 0);
    end
    cyc(0, 0, 1, 0);
    chk("t1_bcd", 32'(bcd), 32'h0037);
    chk("t1_done", 32'(done), 32'h1);
    cyc(0, 0, 0, 0);
    chk("t1_done_once", 32'(done), 32'h0);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
    end
    chk("t1_hold", 32'(bcd), 32'h0037);
    cyc(0, 0, 0, 1);

    // carry ripple and overflow
    cyc(0, 1, 0, 0);
    ticks(99);
    ticks(1);
    chk("t2_0100", 32'(bcd), 32'h0100);
    ticks(899);
    ticks(1);
    chk("t2_1000", 32'(bcd), 32'h1000);
    ticks(8999);
    chk("t3_9999", 32'(bcd), 32'h9999);
    ticks(1);
    chk("t3_sat", 32'(bcd), 32'h9999);
    chk("t3_ovf", 32'(overflow), 32'h1);
    chk("t3_done", 32'(done), 32'h1);
    ticks(5);
    cyc(0, 1, 0, 0);
    cyc(1, 0, 1, 0);
    chk("t3_stuck", 32'(overflow), 32'h1);
    cyc(0, 0, 0, 1);
    chk("t3_clear_bcd", 32'(bcd), 32'h0);
    chk("t3_clear_ovf", 32'(overflow), 32'h0);

    // coincident events
    cyc(0, 1, 0, 0);
    ticks(41);
    cyc(1, 0, 1, 0);
    chk("t4_tickstop", 32'(bcd), 32'h0042);
    chk("t4_stopped", 32'(running), 32'h0);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 1, 0);
    chk("t4_startstop", 32'(running), 32'h0);
    cyc(0, 1, 0, 0);
    ticks(5);
    cyc(1, 0, 0, 1);
    chk("t4_clrtick", 32'(bcd), 32'h0);
    chk("t4_clr_idle", 32'(running), 32'h0);

    // stop/resume with a single done pulse
    done_seen = 0;
    cyc(0, 1, 0, 0);
    ticks(123);
    cyc(0, 0, 1, 0);
    if (done === 1'b1) done_seen++;
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    if (done === 1'b1) done_seen++;
    for (int i = 0; i < 7; i++) begin
      cyc(1, 0, 0, 0);
      if (done === 1'b1) done_seen++;
    end
    chk("t5_0130", 32'(bcd), 32'h0130);
    chk("t5_done_count", 32'(done_seen), 32'd1);
    cyc(0, 0, 0, 1);

    // async reset between edges
    cyc(0, 1, 0, 0);
    ticks(456);
    chk("t6_pre", 32'(bcd), 32'h0456);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_bcd", 32'(bcd), 32'h0);
    chk("t6_async_run", 32'(running), 32'h0);
    chk("t6_async_done", 32'(done), 32'h0);
    m_count = 0; m_state = M_IDLE; m_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 0, 0, 0);
    chk("t6_after", 32'(bcd), 32'h0);

    // randomized control traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 1)),
          1'($urandom_range(0, 15) == 0),
          1'($urandom_range(0, 24) == 0),
          1'($urandom_range(0, 199) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
